// File: rtl/ifu_pkg.sv
// Shared types and constants for the RV32I instruction-fetch unit.
package ifu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } ifu_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } ifu_state_e;
endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO of fetch entries with flush; used as instruction buffer and PC queue.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  ifu_entry_t               din,
  input  logic                     pop,
  output ifu_entry_t               dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, do_push, do_pop;
  ifu_entry_t  mem [DEPTH];

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/ifetch_unit.sv
// RV32I fetch stage: PC register, credit-limited imem requests, in-order response buffer.
// Optional macro IFU_MISALIGN_CHECK_EN adds inst_fault and the FAULT state for misaligned redirects.
module ifetch_unit
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_data
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic            inst_fault
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  ifu_state_e      state, state_n;
  logic            started;
  logic [XLEN-1:0] fetch_pc, rpc;
  logic [CW-1:0]   inflight, inflight_n, drop;
  logic [CW-1:0]   buf_count, pcq_count;
  logic [CW:0]     credit_used;
  logic            req_fire, resp_drop, resp_keep, buf_valid, buf_pop, fault_vld;
  ifu_entry_t      pcq_din, pcq_dout, buf_din, buf_dout;

`ifdef IFU_MISALIGN_CHECK_EN
  assign rpc = redirect_pc;
`else
  assign rpc = redirect_pc & ~32'h3;
`endif

  // started keeps imem_req_valid low through reset and the edge that releases it.
  assign credit_used    = {1'b0, inflight} + {1'b0, buf_count};
  assign imem_req_valid = started & (state == RUN) & (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign resp_drop      = imem_resp_valid & (drop != '0);
  assign resp_keep      = imem_resp_valid & (drop == '0);
  assign inflight_n     = inflight + CW'(req_fire) - CW'(imem_resp_valid);

  assign buf_valid  = (buf_count != '0);
  assign buf_pop    = buf_valid & inst_ready;
  assign inst_valid = buf_valid | fault_vld;
  assign inst_pc    = fault_vld ? fetch_pc : (buf_valid ? buf_dout.pc : '0);
  assign inst_data  = fault_vld ? '0 : (buf_valid ? buf_dout.inst : '0);

  always_comb begin
    state_n = state;
    if (redirect_valid) begin
`ifdef IFU_MISALIGN_CHECK_EN
      state_n = (rpc[1:0] != 2'b00) ? FAULT : RUN;
`else
      state_n = RUN;
`endif
    end
  end

  // Redirect overrides PC advance and drop decrement; drop then counts every
  // request still owed a response, including one handshaken this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started  <= 1'b0;
      state    <= RUN;
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      started  <= 1'b1;
      state    <= state_n;
      inflight <= inflight_n;
      if (redirect_valid) begin
        fetch_pc <= rpc;
        drop     <= inflight_n;
      end else begin
        if (req_fire)  fetch_pc <= fetch_pc + 32'd4;
        if (resp_drop) drop     <= drop - CW'(1);
      end
    end
  end

`ifdef IFU_MISALIGN_CHECK_EN
  logic fault_pend;

  // The fault entry waits until every wrong-path response has drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_pend <= 1'b0;
      fault_vld  <= 1'b0;
    end else if (redirect_valid) begin
      fault_pend <= (rpc[1:0] != 2'b00);
      fault_vld  <= 1'b0;
    end else if (fault_pend && drop == '0) begin
      fault_pend <= 1'b0;
      fault_vld  <= 1'b1;
    end else if (fault_vld && inst_ready) begin
      fault_vld  <= 1'b0;
    end
  end

  assign inst_fault = fault_vld;
`else
  assign fault_vld = 1'b0;
`endif

  always_comb begin
    pcq_din      = '0;
    pcq_din.pc   = fetch_pc;
    buf_din      = pcq_dout;
    buf_din.inst = imem_resp_data;
  end

  ifu_fifo #(.DEPTH(DEPTH)) u_pcq (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (req_fire),
    .din   (pcq_din),
    .pop   (resp_keep & (pcq_count != '0)),
    .dout  (pcq_dout),
    .count (pcq_count)
  );

  ifu_fifo #(.DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (resp_keep),
    .din   (buf_din),
    .pop   (buf_pop),
    .dout  (buf_dout),
    .count (buf_count)
  );
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a 1-cycle in-order memory model and a delivery log.
module tb_ifetch_unit;
  localparam logic [31:0] A0 = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_pc, inst_data;
  logic        inst_fault_w;

  int checks = 0;
  int failures = 0;
  bit hold = 1'b0;
  logic [31:0] mq[$];
  logic [31:0] reqs[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];
  logic        got_flt[$];

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(A0), .DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_pc         (inst_pc),
    .inst_data       (inst_data)
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    .inst_fault      (inst_fault_w)
`endif
  );
`ifndef IFU_MISALIGN_CHECK_EN
  assign inst_fault_w = 1'b0;
`endif

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Memory model: a request seen at a falling edge handshakes on the next rising
  // edge; its response is driven at the following falling edge (latency 1).
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mq.delete();
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end else begin
      if (!hold && mq.size() > 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = memf(mq.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
      end
      if (imem_req_valid && imem_req_ready) mq.push_back(imem_req_addr);
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (imem_req_valid && imem_req_ready) reqs.push_back(imem_req_addr);
      if (inst_valid && inst_ready) begin
        got_pc.push_back(inst_pc);
        got_data.push_back(inst_data);
        got_flt.push_back(inst_fault_w);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    reqs.delete();
    got_pc.delete();
    got_data.delete();
    got_flt.delete();
  endtask

  task automatic do_reset(input bit rq_rdy, input bit in_rdy, input bit hld);
    step(1);
    rst = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = rq_rdy;
    inst_ready = in_rdy;
    hold = hld;
    step(2);
    clear_log();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    step(1);
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    step(3);
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (imem_req_addr !== A0) begin failures++; $display("FAIL rst_req_addr: got %h want %h", imem_req_addr, A0); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
    checks++; if (inst_pc !== 32'h0 || inst_data !== 32'h0) begin failures++; $display("FAIL rst_inst_bus: got pc %h data %h want 0 0", inst_pc, inst_data); end
    checks++; if (inst_fault_w !== 1'b0) begin failures++; $display("FAIL rst_inst_fault: got %b want 0", inst_fault_w); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rel_req_early: got %b want 0", imem_req_valid); end
    step(1);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== A0) begin failures++; $display("FAIL rel_first_req: got v=%b a=%h want v=1 a=%h", imem_req_valid, imem_req_addr, A0); end
  endtask

  task automatic test_stream();
    do_reset(1'b1, 1'b1, 1'b0);
    step(14);
    checks++;
    if (reqs.size() < 3) begin failures++; $display("FAIL stream_reqs: got %0d requests want >=3", reqs.size()); end
    else if (reqs[0] !== A0 || reqs[1] !== A0 + 32'd4 || reqs[2] !== A0 + 32'd8) begin
      failures++; $display("FAIL stream_req_addr: got %h %h %h want %h %h %h", reqs[0], reqs[1], reqs[2], A0, A0 + 32'd4, A0 + 32'd8);
    end
    checks++;
    if (got_pc.size() < 3) begin failures++; $display("FAIL stream_count: got %0d delivered want >=3", got_pc.size()); end
    else begin
      for (int i = 0; i < got_pc.size(); i++) begin
        if (got_pc[i] !== A0 + 32'(4 * i) || got_data[i] !== memf(A0 + 32'(4 * i))) begin
          failures++; $display("FAIL stream_order: entry %0d got pc %h data %h want pc %h data %h", i, got_pc[i], got_data[i], A0 + 32'(4 * i), memf(A0 + 32'(4 * i)));
          break;
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b1, 1'b0, 1'b0);
    step(10);
    checks++; if (reqs.size() != 2) begin failures++; $display("FAIL bp_req_count: got %0d want 2", reqs.size()); end
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== A0 || inst_data !== memf(A0)) begin failures++; $display("FAIL bp_head: got v=%b pc=%h d=%h want v=1 pc=%h d=%h", inst_valid, inst_pc, inst_data, A0, memf(A0)); end
    checks++; if (imem_req_addr !== A0 + 32'd8) begin failures++; $display("FAIL bp_next_addr: got %h want %h", imem_req_addr, A0 + 32'd8); end
    inst_ready = 1'b1;
    step(8);
    checks++;
    if (reqs.size() < 3 || reqs[2] !== A0 + 32'd8) begin failures++; $display("FAIL bp_resume_req: got %0d reqs, third %h want %h", reqs.size(), (reqs.size() > 2) ? reqs[2] : 32'hx, A0 + 32'd8); end
    checks++;
    if (got_pc.size() < 3 || got_pc[0] !== A0 || got_pc[1] !== A0 + 32'd4 || got_pc[2] !== A0 + 32'd8) begin
      failures++; $display("FAIL bp_deliver: got %0d entries want pcs %h %h %h in order", got_pc.size(), A0, A0 + 32'd4, A0 + 32'd8);
    end
  endtask

  task automatic check_redirect(input string nm, input logic [31:0] tgt);
    checks++;
    if (got_pc.size() < 1 || got_pc[0] !== tgt || got_data[0] !== memf(tgt)) begin
      failures++; $display("FAIL %s_first: got %0d entries pc %h data %h want pc %h data %h", nm, got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hx, (got_data.size() > 0) ? got_data[0] : 32'hx, tgt, memf(tgt));
    end
    checks++;
    for (int i = 0; i < got_pc.size(); i++) begin
      if (got_pc[i] < tgt) begin
        failures++; $display("FAIL %s_stale: entry %0d got pc %h want pc >= %h", nm, i, got_pc[i], tgt);
        break;
      end
    end
    checks++;
    if (reqs.size() < 3 || reqs[2] !== tgt) begin failures++; $display("FAIL %s_req: got %0d reqs, third %h want %h", nm, reqs.size(), (reqs.size() > 2) ? reqs[2] : 32'hx, tgt); end
  endtask

  task automatic test_redirect_inflight();
    do_reset(1'b1, 1'b1, 1'b1);
    step(6);
    checks++; if (reqs.size() != 2 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL rdi_setup: got %0d reqs v=%b want 2 v=0", reqs.size(), imem_req_valid); end
    redirect(32'h8000_0100);
    hold = 1'b0;
    step(12);
    check_redirect("rdi", 32'h8000_0100);
  endtask

  task automatic test_redirect_collide();
    do_reset(1'b1, 1'b1, 1'b0);
    step(2);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== A0 + 32'd4) begin failures++; $display("FAIL rdc_setup: got v=%b a=%h want v=1 a=%h", imem_req_valid, imem_req_addr, A0 + 32'd4); end
    redirect(32'h8000_0200);
    step(10);
    check_redirect("rdc", 32'h8000_0200);
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1, 1'b1, 1'b1);
    step(6);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0300;
    step(1);
    redirect_pc = 32'h8000_0400;
    step(1);
    redirect_valid = 1'b0;
    hold = 1'b0;
    step(12);
    check_redirect("b2b", 32'h8000_0400);
    checks++;
    foreach (reqs[i]) begin
      if (reqs[i] == 32'h8000_0300) begin failures++; $display("FAIL b2b_overridden: got request %h want none", reqs[i]); break; end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1, 1'b0, 1'b0);
    step(8);
    checks++; if (inst_valid !== 1'b1 || imem_req_addr !== A0 + 32'd8) begin failures++; $display("FAIL mid_setup: got v=%b a=%h want v=1 a=%h", inst_valid, imem_req_addr, A0 + 32'd8); end
    rst = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== A0) begin failures++; $display("FAIL mid_req: got v=%b a=%h want v=0 a=%h", imem_req_valid, imem_req_addr, A0); end
    checks++; if (inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst_data !== 32'h0) begin failures++; $display("FAIL mid_inst: got v=%b pc=%h d=%h want 0 0 0", inst_valid, inst_pc, inst_data); end
    step(2);
    clear_log();
    rst = 1'b0;
    inst_ready = 1'b1;
    step(8);
    checks++; if (reqs.size() < 1 || reqs[0] !== A0 || got_pc.size() < 1 || got_pc[0] !== A0) begin failures++; $display("FAIL mid_restart: got %0d reqs %0d entries want first req and entry at %h", reqs.size(), got_pc.size(), A0); end
  endtask

  task automatic test_misalign();
    do_reset(1'b1, 1'b1, 1'b1);
    step(6);
    redirect(32'h8000_0102);
    hold = 1'b0;
    step(12);
`ifdef IFU_MISALIGN_CHECK_EN
    checks++; if (reqs.size() != 2 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL mis_noreq: got %0d reqs v=%b want 2 v=0", reqs.size(), imem_req_valid); end
    checks++;
    if (got_pc.size() != 1 || got_pc[0] !== 32'h8000_0102 || got_data[0] !== 32'h0 || got_flt[0] !== 1'b1) begin
      failures++; $display("FAIL mis_entry: got %0d entries pc %h data %h fault %b want 1 entry 80000102 0 1", got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hx, (got_data.size() > 0) ? got_data[0] : 32'hx, (got_flt.size() > 0) ? got_flt[0] : 1'bx);
    end
    redirect(32'h8000_0200);
    step(10);
    checks++;
    if (got_pc.size() < 2 || got_pc[1] !== 32'h8000_0200 || got_data[1] !== memf(32'h8000_0200) || got_flt[1] !== 1'b0) begin
      failures++; $display("FAIL mis_resume: got %0d entries second pc %h want pc 80000200 fault 0", got_pc.size(), (got_pc.size() > 1) ? got_pc[1] : 32'hx);
    end
`else
    check_redirect("mis_align", 32'h8000_0100);
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collide();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
